id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage; sits between decode/register-file read and the ALU, producing the ALU's two operands and 4-bit operation code.
- Resolves RAW hazards by EX/MEM and MEM/WB forwarding, detects load-use hazards and inserts bubbles.
- Handles downstream stall and branch flush.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  stage accepts the decode instruction this cycle.
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decode payload.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_ADDR_W each  register indices.
- id_alu_control  in  4  ALU operation code, passed through unchanged.
- id_alu_src_a  in  1  1 selects PC as operand A.
- id_alu_src_b  in  1  1 selects immediate as operand B.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits.
- mem_reg_write  in  1  EX/MEM writeback enable.
- mem_rd_addr  in  REG_ADDR_W  EX/MEM destination register.
- mem_fwd_data  in  XLEN  EX/MEM ALU result.
- wb_reg_write  in  1  MEM/WB writeback enable.
- wb_rd_addr  in  REG_ADDR_W  MEM/WB destination register.
- wb_data  in  XLEN  MEM/WB writeback data.
- ex_stall  in  1  downstream cannot advance.
- flush  in  1  kill the instruction in EX (taken branch/jump).
- ex_valid  out  1  EX holds a live instruction.
- ex_alu_a, ex_alu_b  out  XLEN  ALU operands.
- ex_alu_control  out  4  ALU operation code.
- ex_store_data  out  XLEN  forwarded rs2 value for stores.
- ex_pc  out  XLEN  PC of the EX instruction.
- ex_rd_addr  out  REG_ADDR_W  EX destination register.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  qualified control bits.
- load_use_stall  out  1  load-use bubble being inserted.

Behaviour:
- Reset: rst_n low asynchronously clears all registers. Every output reads 0 except id_ready, which reads 1.
- Capture bypass: when a field is captured from decode and wb_reg_write=1, wb_rd_addr!=0 and wb_rd_addr equals id_rsN_addr, store wb_data instead of id_rsN_data.
- Forwarding (combinational on registered rs1/rs2), per operand:
  - Use mem_fwd_data if mem_reg_write=1, mem_rd_addr!=0 and mem_rd_addr matches.
  - Else use wb_data if the same conditions hold on the WB side.
  - Else use the stored value.
  - MEM takes priority over WB. x0 is never forwarded.
- Operand select:
  - ex_alu_a = src_a ? ex_pc : fwd_rs1.
  - ex_alu_b = src_b ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- load_use_stall = ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr). Conservative: both source fields are compared even when unused.
- id_ready = !ex_stall & !load_use_stall & !flush.
- Clock-edge update, highest priority first:
  1. flush=1: ex_valid<=0 and reg_write, mem_read, mem_write <=0. Applies regardless of ex_stall. The decode instruction is not accepted.
  2. ex_stall=1: hold all fields. Stored rs1/rs2 are refreshed with the forwarded values, so data from a retiring WB is not lost while the stage waits.
  3. load_use_stall=1: insert a bubble (ex_valid and control bits <=0). Decode holds.
  4. Otherwise: capture decode. ex_valid<=id_valid; control bits <= id_* & id_valid.
- Latency: 1 cycle from acceptance to EX outputs. Operands become valid combinationally in that cycle.
- Load-use costs exactly one bubble. On the following cycle the load is in MEM/WB and is forwarded from WB.
- Payload fields may update while ex_valid=0. Consumers qualify on ex_valid.

Optional Feature:
- ID_EX_PERF_EN defined adds these outputs:
  - perf_bubbles (32-bit): increments on each inserted load-use bubble.
  - perf_stalls (32-bit): increments on each ex_stall cycle.
  - perf_flushes (32-bit): increments on each flush.
  - All three saturate at 0xFFFFFFFF and are cleared by rst_n.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: rst_n low mid-operation with ex_valid=1 -> all outputs 0 immediately (async), id_ready=1.
- Basic capture: accept id_rs1_data=5, id_rs2_data=7, alu_control=ADD, src_a=src_b=0 -> next cycle ex_alu_a=5, ex_alu_b=7, ex_valid=1.
- Forward priority: rs1=x3, mem_rd=3 with data 0x11, wb_rd=3 with data 0x22 -> ex_alu_a=0x11. With mem_reg_write=0 -> 0x22. With rd=x0 -> stored value.
- Load-use: EX holds lw x4, decode presents add x5,x4,x1 -> load_use_stall=1, id_ready=0, one bubble (ex_valid=0). Next cycle add is accepted and rs1 takes wb_data.
- Stall then flush: ex_stall=1 for 3 cycles -> outputs held and WB data retiring mid-stall is retained. Then flush=1 together with ex_stall=1 -> ex_valid=0 and ex_mem_write=0 next cycle.
- Immediate/PC path: src_a=1, src_b=1, pc=0x100, imm=0xFFFFFFFC -> ex_alu_a=0x100, ex_alu_b=0xFFFFFFFC, ex_store_data=forwarded rs2.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion, stall and flush.
// Define ID_EX_PERF_EN to add saturating bubble/stall/flush event counters.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [3:0]            id_alu_control,
  input  logic                  id_alu_src_a,
  input  logic                  id_alu_src_b,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]       mem_fwd_data,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_alu_a,
  output logic [XLEN-1:0]       ex_alu_b,
  output logic [3:0]            ex_alu_control,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [XLEN-1:0]       ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  load_use_stall
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]           perf_bubbles,
  output logic [31:0]           perf_stalls,
  output logic [31:0]           perf_flushes
`endif
);

  logic                  r_valid;
  logic [XLEN-1:0]       r_pc, r_rs1, r_rs2, r_imm;
  logic [REG_ADDR_W-1:0] r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic [3:0]            r_alu_control;
  logic                  r_src_a, r_src_b;
  logic                  r_reg_write, r_mem_read, r_mem_write;

  logic                  w_mem_hit1, w_mem_hit2, w_wb_hit1, w_wb_hit2;
  logic                  w_cap_hit1, w_cap_hit2;
  logic [XLEN-1:0]       w_fwd_rs1, w_fwd_rs2;
  logic [XLEN-1:0]       w_cap_rs1, w_cap_rs2;
  logic                  w_load_use;

  // Forwarding on the registered source indices; MEM wins over WB, x0 never forwards.
  assign w_mem_hit1 = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == r_rs1_addr);
  assign w_mem_hit2 = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == r_rs2_addr);
  assign w_wb_hit1  = wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == r_rs1_addr);
  assign w_wb_hit2  = wb_reg_write  && (wb_rd_addr  != '0) && (wb_rd_addr  == r_rs2_addr);

  assign w_fwd_rs1 = w_mem_hit1 ? mem_fwd_data : (w_wb_hit1 ? wb_data : r_rs1);
  assign w_fwd_rs2 = w_mem_hit2 ? mem_fwd_data : (w_wb_hit2 ? wb_data : r_rs2);

  // WB writing the register file this cycle is not yet visible in the decode read data.
  assign w_cap_hit1 = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs1_addr);
  assign w_cap_hit2 = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == id_rs2_addr);
  assign w_cap_rs1  = w_cap_hit1 ? wb_data : id_rs1_data;
  assign w_cap_rs2  = w_cap_hit2 ? wb_data : id_rs2_data;

  assign w_load_use = r_valid && r_mem_read && (r_rd_addr != '0) && id_valid &&
                      ((r_rd_addr == id_rs1_addr) || (r_rd_addr == id_rs2_addr));

  assign load_use_stall = w_load_use;
  assign id_ready       = !ex_stall && !w_load_use && !flush;

  assign ex_valid       = r_valid;
  assign ex_alu_a       = r_src_a ? r_pc  : w_fwd_rs1;
  assign ex_alu_b       = r_src_b ? r_imm : w_fwd_rs2;
  assign ex_store_data  = w_fwd_rs2;
  assign ex_alu_control = r_alu_control;
  assign ex_pc          = r_pc;
  assign ex_rd_addr     = r_rd_addr;
  assign ex_reg_write   = r_reg_write;
  assign ex_mem_read    = r_mem_read;
  assign ex_mem_write   = r_mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_imm         <= '0;
      r_rs1_addr    <= '0;
      r_rs2_addr    <= '0;
      r_rd_addr     <= '0;
      r_alu_control <= '0;
      r_src_a       <= 1'b0;
      r_src_b       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (ex_stall) begin
      // Latch forwarded values so a producer retiring mid-stall is not lost.
      r_rs1 <= w_fwd_rs1;
      r_rs2 <= w_fwd_rs2;
    end else if (w_load_use) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_valid       <= id_valid;
      r_pc          <= id_pc;
      r_rs1         <= w_cap_rs1;
      r_rs2         <= w_cap_rs2;
      r_imm         <= id_imm;
      r_rs1_addr    <= id_rs1_addr;
      r_rs2_addr    <= id_rs2_addr;
      r_rd_addr     <= id_rd_addr;
      r_alu_control <= id_alu_control;
      r_src_a       <= id_alu_src_a;
      r_src_b       <= id_alu_src_b;
      r_reg_write   <= id_reg_write & id_valid;
      r_mem_read    <= id_mem_read  & id_valid;
      r_mem_write   <= id_mem_write & id_valid;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] r_perf_bubbles, r_perf_stalls, r_perf_flushes;
  logic        w_bubble;

  assign w_bubble = w_load_use && !ex_stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_bubbles <= '0;
      r_perf_stalls  <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_bubble && (r_perf_bubbles != '1)) r_perf_bubbles <= r_perf_bubbles + 32'd1;
      if (ex_stall && (r_perf_stalls  != '1)) r_perf_stalls  <= r_perf_stalls  + 32'd1;
      if (flush    && (r_perf_flushes != '1)) r_perf_flushes <= r_perf_flushes + 32'd1;
    end
  end

  assign perf_bubbles = r_perf_bubbles;
  assign perf_stalls  = r_perf_stalls;
  assign perf_flushes = r_perf_flushes;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected EX contents, a negedge monitor checks them.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid, id_ready;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RW-1:0]   id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]      id_alu_control;
  logic            id_alu_src_a, id_alu_src_b;
  logic            id_reg_write, id_mem_read, id_mem_write;
  logic            mem_reg_write;
  logic [RW-1:0]   mem_rd_addr;
  logic [XLEN-1:0] mem_fwd_data;
  logic            wb_reg_write;
  logic [RW-1:0]   wb_rd_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_stall, flush;
  logic            ex_valid;
  logic [XLEN-1:0] ex_alu_a, ex_alu_b, ex_store_data, ex_pc;
  logic [3:0]      ex_alu_control;
  logic [RW-1:0]   ex_rd_addr;
  logic            ex_reg_write, ex_mem_read, ex_mem_write;
  logic            load_use_stall;
`ifdef ID_EX_PERF_EN
  logic [31:0]     perf_bubbles, perf_stalls, perf_flushes;
`endif

  id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_control(id_alu_control), .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
    .ex_alu_control(ex_alu_control), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
`ifdef ID_EX_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] a, b, st, pc;
    logic [RW-1:0]   rd;
    logic [3:0]      ctl;
    logic            rw, mr, mw;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] st,
                      input logic [XLEN-1:0] pc, input logic [RW-1:0] rd, input logic [3:0] ctl,
                      input logic rw, input logic mr, input logic mw);
    exp_t e;
    e.a = a; e.b = b; e.st = st; e.pc = pc; e.rd = rd; e.ctl = ctl; e.rw = rw; e.mr = mr; e.mw = mw;
    q.push_back(e);
  endtask

  task automatic issue(input logic [XLEN-1:0] pc, input logic [RW-1:0] r1a, input logic [XLEN-1:0] r1d,
                       input logic [RW-1:0] r2a, input logic [XLEN-1:0] r2d, input logic [RW-1:0] rd,
                       input logic [XLEN-1:0] imm, input logic [3:0] ctl, input logic sa, input logic sb,
                       input logic rw, input logic mr, input logic mw);
    id_valid = 1'b1; id_pc = pc; id_rs1_addr = r1a; id_rs1_data = r1d; id_rs2_addr = r2a;
    id_rs2_data = r2d; id_rd_addr = rd; id_imm = imm; id_alu_control = ctl;
    id_alu_src_a = sa; id_alu_src_b = sb; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_pc = '0; id_rs1_addr = '0; id_rs1_data = '0; id_rs2_addr = '0;
    id_rs2_data = '0; id_rd_addr = '0; id_imm = '0; id_alu_control = '0;
    id_alu_src_a = 1'b0; id_alu_src_b = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
  endtask

  task automatic fwd(input logic mw, input logic [RW-1:0] md, input logic [XLEN-1:0] mdat,
                     input logic ww, input logic [RW-1:0] wd, input logic [XLEN-1:0] wdat);
    mem_reg_write = mw; mem_rd_addr = md; mem_fwd_data = mdat;
    wb_reg_write = ww; wb_rd_addr = wd; wb_data = wdat;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ex_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_alu_a"}, ex_alu_a, 32'd0);
    chk({tag, "_alu_b"}, ex_alu_b, 32'd0);
    chk({tag, "_store"}, ex_store_data, 32'd0);
    chk({tag, "_pc"}, ex_pc, 32'd0);
    chk({tag, "_rd_ctl"}, {23'd0, ex_rd_addr, ex_alu_control}, 32'd0);
    chk({tag, "_ctrl"}, {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    chk({tag, "_lu"}, {31'd0, load_use_stall}, 32'd0);
    chk({tag, "_id_ready"}, {31'd0, id_ready}, 32'd1);
  endtask

  // Monitor: every live EX cycle must match the next scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ex_valid) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL ex_unexpected: ex_valid=1 pc=%h with no entry queued", ex_pc);
        end else begin
          mon_e = q.pop_front();
          if ({ex_alu_a, ex_alu_b, ex_store_data, ex_pc, ex_rd_addr, ex_alu_control,
               ex_reg_write, ex_mem_read, ex_mem_write} !==
              {mon_e.a, mon_e.b, mon_e.st, mon_e.pc, mon_e.rd, mon_e.ctl, mon_e.rw, mon_e.mr, mon_e.mw}) begin
            n_fail++;
            $display("FAIL ex_out pc=%h: got a=%h b=%h st=%h rd=%0d ctl=%h c=%b%b%b expected a=%h b=%h st=%h pc=%h rd=%0d ctl=%h c=%b%b%b",
                     ex_pc, ex_alu_a, ex_alu_b, ex_store_data, ex_rd_addr, ex_alu_control,
                     ex_reg_write, ex_mem_read, ex_mem_write,
                     mon_e.a, mon_e.b, mon_e.st, mon_e.pc, mon_e.rd, mon_e.ctl, mon_e.rw, mon_e.mr, mon_e.mw);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    idle(); fwd(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #2 chk_reset("rst_init");
    tick(); tick();
    rst_n = 1'b1;

    // Basic capture: ADD with register operands.
    issue(32'h10, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd0, 4'h0, 0, 0, 1, 0, 0);
    #1 chk("basic_id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    idle(); push(32'd5, 32'd7, 32'd7, 32'h10, 5'd3, 4'h0, 1, 0, 0);
    tick();
    chk("basic_after_valid", {31'd0, ex_valid}, 32'd0);

    // Forwarding priority: MEM over WB.
    issue(32'h20, 5'd3, 32'h99, 5'd4, 32'h44, 5'd6, 32'd0, 4'h1, 0, 0, 1, 0, 0);
    tick();
    idle(); fwd(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    push(32'h11, 32'h44, 32'h44, 32'h20, 5'd6, 4'h1, 1, 0, 0);
    tick();
    fwd(0, 0, 0, 0, 0, 0);
    issue(32'h24, 5'd3, 32'h99, 5'd4, 32'h44, 5'd6, 32'd0, 4'h1, 0, 0, 1, 0, 0);
    tick();
    idle(); fwd(0, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    push(32'h22, 32'h44, 32'h44, 32'h24, 5'd6, 4'h1, 1, 0, 0);
    tick();
    fwd(0, 0, 0, 0, 0, 0);
    issue(32'h28, 5'd0, 32'h99, 5'd4, 32'h44, 5'd6, 32'd0, 4'h1, 0, 0, 1, 0, 0);
    tick();
    idle(); fwd(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
    push(32'h99, 32'h44, 32'h44, 32'h28, 5'd6, 4'h1, 1, 0, 0);
    tick();
    fwd(0, 0, 0, 0, 0, 0);

    // Load-use: lw x4 then add x5,x4,x1.
    issue(32'h30, 5'd1, 32'h1000, 5'd0, 32'd0, 5'd4, 32'd8, 4'h0, 0, 1, 1, 1, 0);
    tick();
    push(32'h1000, 32'd8, 32'd0, 32'h30, 5'd4, 4'h0, 1, 1, 0);
    issue(32'h34, 5'd4, 32'hDEAD, 5'd1, 32'h1000, 5'd5, 32'd0, 4'h0, 0, 0, 1, 0, 0);
    #1 chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
    chk("lu_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    fwd(0, 0, 0, 1, 5'd4, 32'h77);
    #1 chk("lu_release", {30'd0, load_use_stall, id_ready}, 32'd1);
    tick();
    idle(); fwd(0, 0, 0, 0, 0, 0);
    push(32'h77, 32'h1000, 32'h1000, 32'h34, 5'd5, 4'h0, 1, 0, 0);
    tick();

    // Load to x0 never creates a hazard.
    issue(32'h50, 5'd1, 32'h10, 5'd0, 32'd0, 5'd0, 32'd0, 4'h0, 0, 1, 1, 1, 0);
    tick();
    push(32'h10, 32'd0, 32'd0, 32'h50, 5'd0, 4'h0, 1, 1, 0);
    issue(32'h54, 5'd0, 32'd3, 5'd0, 32'd4, 5'd11, 32'd0, 4'h0, 0, 0, 1, 0, 0);
    #1 chk("lu_x0", {30'd0, load_use_stall, id_ready}, 32'd1);
    tick();
    idle(); push(32'd3, 32'd4, 32'd4, 32'h54, 5'd11, 4'h0, 1, 0, 0);
    tick();

    // Stall three cycles with WB retiring mid-stall, then flush under stall.
    issue(32'h40, 5'd2, 32'h200, 5'd7, 32'h70, 5'd0, 32'd4, 4'h0, 0, 1, 0, 0, 1);
    tick();
    ex_stall = 1'b1;
    issue(32'h99, 5'd9, 32'hBAD, 5'd9, 32'hBAD, 5'd9, 32'd0, 4'hF, 0, 0, 1, 0, 0);
    push(32'h200, 32'd4, 32'h70, 32'h40, 5'd0, 4'h0, 0, 0, 1);
    #1 chk("stall_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    fwd(0, 0, 0, 1, 5'd7, 32'h7777);
    push(32'h200, 32'd4, 32'h7777, 32'h40, 5'd0, 4'h0, 0, 0, 1);
    tick();
    fwd(0, 0, 0, 0, 0, 0);
    push(32'h200, 32'd4, 32'h7777, 32'h40, 5'd0, 4'h0, 0, 0, 1);
    tick();
    flush = 1'b1;
    push(32'h200, 32'd4, 32'h7777, 32'h40, 5'd0, 4'h0, 0, 0, 1);
    #1 chk("flush_id_ready", {31'd0, id_ready}, 32'd0);
    tick();
    flush = 1'b0; ex_stall = 1'b0; idle();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_mem_write", {31'd0, ex_mem_write}, 32'd0);
    tick();

    // Immediate / PC operand path, rs2 forwarded from MEM to store data.
    issue(32'h100, 5'd8, 32'h1, 5'd9, 32'h5, 5'd10, 32'hFFFFFFFC, 4'h2, 1, 1, 1, 0, 0);
    tick();
    idle(); fwd(1, 5'd9, 32'hABC, 0, 0, 0);
    push(32'h100, 32'hFFFFFFFC, 32'hABC, 32'h100, 5'd10, 4'h2, 1, 0, 0);
    tick();
    fwd(0, 0, 0, 0, 0, 0);

    // Asynchronous reset while EX is live.
    issue(32'h60, 5'd1, 32'h5, 5'd2, 32'h6, 5'd12, 32'd0, 4'h3, 0, 0, 1, 0, 1);
    tick();
    idle();
    chk("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
    rst_n = 1'b0;
    #1 chk_reset("rst_async");
    tick();
    rst_n = 1'b1;
    tick(); tick();

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
